// File: rtl/processing_element.sv
// Weight-stationary systolic-array processing element.
// Forwards the activation along the row, accumulates activation*WEIGHT into the
// column partial sum (saturating at 19 bits), and emits a rounded, shifted,
// saturated 8-bit result.
// Optional build macro: PE_RELU_EN -- when defined, out_c lower clamp is 0.
module processing_element #(
   parameter int          WEIGHT = 1,   // signed stationary weight, -128..127
   parameter int unsigned SHIFT  = 0    // requantization right-shift, 0..18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_a,
   input  logic [18:0] in_b,
   output logic [7:0]  out_a,
   output logic [18:0] out_b,
   output logic [7:0]  out_c
);

   localparam int unsigned A_W = 8;
   localparam int unsigned B_W = 19;
   localparam int unsigned P_W = 17;
   localparam int unsigned S_W = 20;
   localparam int unsigned C_W = 8;

   localparam logic signed [A_W-1:0] W_S = A_W'(WEIGHT);

   // Half-LSB rounding offset; zero when no shift is applied.
   localparam int unsigned           RND_I = (32'(1) << SHIFT) >> 1;
   localparam logic signed [S_W-1:0] RND   = S_W'(RND_I);

   localparam logic signed [S_W-1:0] B_MAX = S_W'(262143);
   localparam logic signed [S_W-1:0] B_MIN = -S_W'(262144);
   localparam logic signed [S_W-1:0] C_MAX = S_W'(127);
`ifdef PE_RELU_EN
   localparam logic signed [S_W-1:0] C_MIN = S_W'(0);
`else
   localparam logic signed [S_W-1:0] C_MIN = -S_W'(128);
`endif

   logic signed [P_W-1:0] a_ext_c;
   logic signed [P_W-1:0] w_ext_c;
   logic signed [P_W-1:0] prod_c;
   logic signed [S_W-1:0] sum_c;
   logic signed [S_W-1:0] q_c;
   logic        [B_W-1:0] b_nxt_c;
   logic        [C_W-1:0] c_nxt_c;

   // Unsigned activation times signed weight; the 17-bit product never overflows.
   always_comb begin
      a_ext_c = P_W'(signed'({1'b0, in_a}));
      w_ext_c = P_W'(W_S);
      prod_c  = a_ext_c * w_ext_c;
   end

   // Wide accumulate so the sum cannot wrap before saturation.
   always_comb begin
      sum_c = S_W'(signed'(in_b)) + S_W'(prod_c);
   end

   // Saturate the partial sum to the signed 19-bit column range.
   always_comb begin
      b_nxt_c = sum_c[B_W-1:0];
      if (sum_c > B_MAX) begin
         b_nxt_c = B_MAX[B_W-1:0];
      end else if (sum_c < B_MIN) begin
         b_nxt_c = B_MIN[B_W-1:0];
      end
   end

   // Requantize from the unsaturated sum: round half up, arithmetic shift, clamp.
   always_comb begin
      q_c     = (sum_c + RND) >>> SHIFT;
      c_nxt_c = q_c[C_W-1:0];
      if (q_c > C_MAX) begin
         c_nxt_c = C_MAX[C_W-1:0];
      end else if (q_c < C_MIN) begin
         c_nxt_c = C_MIN[C_W-1:0];
      end
   end

   // Output registers; reset clears them immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_a <= '0;
         out_b <= '0;
         out_c <= '0;
      end else begin
         out_a <= in_a;
         out_b <= b_nxt_c;
         out_c <= c_nxt_c;
      end
   end

endmodule

// File: tb/tb_processing_element.sv
// Scoreboard bench for processing_element: several instances with different
// WEIGHT/SHIFT share one input stream; expectations come from an arithmetic model.
module tb_processing_element;

   localparam int N = 5;
   localparam int WT [N] = '{1, 127, -128, 1, -37};
   localparam int SH [N] = '{0, 0, 0, 2, 5};

   logic        clk;
   logic        reset;
   logic [7:0]  in_a;
   logic [18:0] in_b;
   logic [7:0]         oa [N];
   logic signed [18:0] ob [N];
   logic signed [7:0]  oc [N];

   typedef struct {
      int a;
      int b [N];
      int c [N];
   } exp_t;

   exp_t q [$];
   int checks = 0;
   int errors = 0;

   processing_element #(.WEIGHT(WT[0]), .SHIFT(SH[0])) u0 (.clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .out_a(oa[0]), .out_b(ob[0]), .out_c(oc[0]));
   processing_element #(.WEIGHT(WT[1]), .SHIFT(SH[1])) u1 (.clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .out_a(oa[1]), .out_b(ob[1]), .out_c(oc[1]));
   processing_element #(.WEIGHT(WT[2]), .SHIFT(SH[2])) u2 (.clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .out_a(oa[2]), .out_b(ob[2]), .out_c(oc[2]));
   processing_element #(.WEIGHT(WT[3]), .SHIFT(SH[3])) u3 (.clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .out_a(oa[3]), .out_b(ob[3]), .out_c(oc[3]));
   processing_element #(.WEIGHT(WT[4]), .SHIFT(SH[4])) u4 (.clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .out_a(oa[4]), .out_b(ob[4]), .out_c(oc[4]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int clampi(int v, int lo, int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Reference: exact integer sum, real-valued round-half-up divide by 2^SHIFT.
   function automatic exp_t model(int a, int b);
      exp_t e;
      int   sum;
      real  r;
      int   lo;
`ifdef PE_RELU_EN
      lo = 0;
`else
      lo = -128;
`endif
      e.a = a;
      for (int i = 0; i < N; i++) begin
         sum    = b + a * WT[i];
         e.b[i] = clampi(sum, -262144, 262143);
         r      = $floor(real'(sum) / (2.0 ** SH[i]) + 0.5);
         e.c[i] = clampi(int'(r), lo, 127);
      end
      return e;
   endfunction

   task automatic cmp(string name, int idx, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, idx, act, exp, $time);
      end
   endtask

   task automatic check_zero();
      for (int i = 0; i < N; i++) begin
         cmp("reset_out_a", i, int'(oa[i]), 0);
         cmp("reset_out_b", i, int'(ob[i]), 0);
         cmp("reset_out_c", i, int'(oc[i]), 0);
      end
   endtask

   // Apply one sample on the falling edge and queue its expected response.
   task automatic drive(int a, int b);
      @(negedge clk);
      in_a = 8'(a);
      in_b = 19'(b);
      q.push_back(model(a, b));
   endtask

   // Monitor: one sample in flight produces one output one cycle later.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!reset && q.size() > 0) begin
         e = q.pop_front();
         for (int i = 0; i < N; i++) begin
            cmp("out_a", i, int'(oa[i]), e.a);
            cmp("out_b", i, int'(ob[i]), e.b[i]);
            cmp("out_c", i, int'(oc[i]), e.c[i]);
         end
      end
   end

   function automatic int rand_b();
      case ($urandom_range(0, 3))
         0: return ($urandom_range(0, 1) == 0) ? 262143 : -262144;
         default: return int'($urandom_range(0, 524287)) - 262144;
      endcase
   endfunction

   initial begin
      int drain;
      reset = 1'b1;
      in_a  = 8'd0;
      in_b  = 19'd0;
      repeat (2) @(negedge clk);
      check_zero();
      reset = 1'b0;

      drive(15, 10);
      drive(45, -3);
      drive(10, -2);
      drive(255, 262143);
      drive(255, -262144);
      drive(0, -200);
      drive(0, 10);
      drive(0, -10);
      drive(0, 9);

      // Mid-cycle reset with nonzero outputs, inputs kept busy during reset.
      drive(200, 1000);
      @(posedge clk);
      #2;
      reset = 1'b1;
      in_a  = 8'd77;
      in_b  = 19'd5000;
      #1;
      check_zero();
      @(posedge clk);
      #2;
      check_zero();
      @(negedge clk);
      reset = 1'b0;

      for (int n = 0; n < 40; n++) begin
         drive(int'($urandom_range(0, 255)), rand_b());
      end

      drain = 0;
      while (q.size() > 0 && drain < 5) begin
         @(negedge clk);
         drain++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
